ex_serial_alu: RTL

- Execute stage that consumes the ID/EX pipeline register outputs and produces the write-back triple for EX/MEM.
- Also drives a stall request back toward pipeline control (the reverse direction).
- Single-cycle ops (add/sub/compare/logic) resolve combinationally.
- Shifts run through a serial 1-bit-per-cycle shifter, holding the pipeline via stallreq_o until the result is ready.

---
 rtl/ex_serial_alu.sv | 77 +++++++
 1 files changed

// File: rtl/ex_serial_alu.sv
// ex_serial_alu: execute stage with combinational ALU ops and a 1-bit-per-cycle serial shifter
// Inputs:  clk, rst (async, active low), aluop_i/alufunct3_i/alt_i decode, reg1_i/reg2_i operands,
//          wreg_i/wd_i write-back address and enable from ID/EX.
// Outputs: wd_o/wreg_o/wdata_o write-back triple to EX/MEM, stallreq_o freeze request while shifting.
module ex_serial_alu #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      aluop_i,
    input  logic [2:0]      alufunct3_i,
    input  logic            alt_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    input  logic [4:0]      wreg_i,
    input  logic            wd_i,
    output logic            wd_o,
    output logic [4:0]      wreg_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            stallreq_o
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t          state, state_nx;
    logic [XLEN-1:0] acc, res;
    logic [SHW-1:0]  cnt, shamt;
    logic            sh_left, sh_arith;
    logic            is_op, valid, is_shift, start, slt, sltu;
    assign is_op    = aluop_i == 7'b0110011;
    assign valid    = is_op || aluop_i == 7'b0010011;
    assign is_shift = valid && alufunct3_i[1:0] == 2'b01;
    assign shamt    = reg2_i[SHW-1:0];
    assign start    = state == IDLE && is_shift && shamt != '0;
    assign slt      = $signed(reg1_i) < $signed(reg2_i);
    assign sltu     = reg1_i < reg2_i;
    always_comb begin
        res = !valid                ? '0 :
              alufunct3_i == 3'b000 ? ((is_op && alt_i) ? reg1_i - reg2_i : reg1_i + reg2_i) :
              alufunct3_i == 3'b010 ? {{(XLEN-1){1'b0}}, slt} :
              alufunct3_i == 3'b011 ? {{(XLEN-1){1'b0}}, sltu} :
              alufunct3_i == 3'b100 ? reg1_i ^ reg2_i :
              alufunct3_i == 3'b110 ? reg1_i | reg2_i :
              alufunct3_i == 3'b111 ? reg1_i & reg2_i :
                                      reg1_i;
        state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
                   state == SHIFT ? (cnt == SHW'(1) ? DONE : SHIFT) :
                                    IDLE;
        stallreq_o = rst && (start || state == SHIFT);
        wd_o       = rst && !stallreq_o && (state == DONE ? wd_i : valid && wd_i);
        wreg_o     = rst ? wreg_i : 5'd0;
        wdata_o    = !rst          ? '0 :
                     state == DONE ? acc :
                     stallreq_o    ? '0 :
                                     res;
    end
    // Direction is latched at start so a protocol-violating input change mid-shift cannot redirect it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            sh_left  <= 1'b0;
            sh_arith <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                acc      <= reg1_i;
                cnt      <= shamt;
                sh_left  <= alufunct3_i[2] == 1'b0;
                sh_arith <= alt_i;
            end else if (state == SHIFT) begin
                acc <= sh_left ? {acc[XLEN-2:0], 1'b0} : {sh_arith & acc[XLEN-1], acc[XLEN-1:1]};
                cnt <= cnt - SHW'(1);
            end
        end
    end
endmodule
